// File: rtl/bram_port_arbiter_pkg.sv
// rtl/bram_port_arbiter_pkg.sv - shared defaults and FSM encoding for the BRAM port arbiter
package bram_port_arbiter_pkg;

  localparam int ADDR_W_DEF       = 10;
  localparam int DATA_W_DEF       = 36;
  localparam int LOCK_TIMEOUT_DEF = 16;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_LOCK0 = 2'd1,
    ST_LOCK1 = 2'd2
  } arb_state_t;

endpackage

// File: rtl/bram_port_arbiter_rr.sv
// rtl/bram_port_arbiter_rr.sv - 2-way round-robin picker (rr_arb2)
module rr_arb2 (
  input  logic i_req0,
  input  logic i_req1,
  input  logic i_last1,   // 1 = requester 1 was granted most recently
  output logic o_gnt0,
  output logic o_gnt1
);

  // On a tie, favour the requester that did not win last time.
  assign o_gnt0 = i_req0 & (~i_req1 | i_last1);
  assign o_gnt1 = i_req1 & (~i_req0 | ~i_last1);

endmodule

// File: rtl/bram_port_arbiter.sv
// rtl/bram_port_arbiter.sv - two-requester single-port BRAM arbiter with lock and lock timeout
module bram_port_arbiter
  import bram_port_arbiter_pkg::*;
#(
  parameter int ADDR_W       = ADDR_W_DEF,
  parameter int DATA_W       = DATA_W_DEF,
  parameter int LOCK_TIMEOUT = LOCK_TIMEOUT_DEF
) (
  input  logic              clock,
  input  logic              reset_n,
  input  logic              io_req0_valid,
  output logic              io_req0_ready,
  input  logic              io_req0_writeEn,
  input  logic              io_req0_lock,
  input  logic [ADDR_W-1:0] io_req0_addr,
  input  logic [DATA_W-1:0] io_req0_dataIn,
  input  logic              io_req1_valid,
  output logic              io_req1_ready,
  input  logic              io_req1_writeEn,
  input  logic              io_req1_lock,
  input  logic [ADDR_W-1:0] io_req1_addr,
  input  logic [DATA_W-1:0] io_req1_dataIn,
  output logic              io_resp0_valid,
  output logic [DATA_W-1:0] io_resp0_dataOut,
  output logic              io_resp1_valid,
  output logic [DATA_W-1:0] io_resp1_dataOut,
  output logic              io_bram_en,
  output logic              io_bram_writeEn,
  output logic [ADDR_W-1:0] io_bram_addr,
  output logic [DATA_W-1:0] io_bram_dataIn,
  input  logic [DATA_W-1:0] io_bram_dataOut,
  output logic              io_lockTimeout
);

  localparam int CNT_W = (LOCK_TIMEOUT > 2) ? $clog2(LOCK_TIMEOUT) : 1;

  arb_state_t       r_state;
  arb_state_t       w_state_nxt;
  logic [CNT_W-1:0] r_cnt;
  logic [CNT_W-1:0] w_cnt_nxt;
  logic             r_last1;
  logic             r_resp0_valid;
  logic             r_resp1_valid;
  logic             r_lock_timeout;
  logic             w_pick0;
  logic             w_pick1;
  logic             w_fire0;
  logic             w_fire1;
  logic             w_own_fire;
  logic             w_own_lock;
  logic             w_cnt_last;
  logic             w_timeout;

  rr_arb2 u_rr (
    .i_req0  (io_req0_valid),
    .i_req1  (io_req1_valid),
    .i_last1 (r_last1),
    .o_gnt0  (w_pick0),
    .o_gnt1  (w_pick1)
  );

  // Grant: round-robin pick when idle, owner only when locked; nothing while in reset.
  always_comb begin
    w_fire0 = 1'b0;
    w_fire1 = 1'b0;
    case (r_state)
      ST_IDLE: begin
        w_fire0 = w_pick0;
        w_fire1 = w_pick1;
      end
      ST_LOCK0: w_fire0 = io_req0_valid;
      ST_LOCK1: w_fire1 = io_req1_valid;
      default: ;
    endcase
    w_fire0 = w_fire0 & reset_n;
    w_fire1 = w_fire1 & reset_n;
  end

  assign w_own_fire = (r_state == ST_LOCK0) ? w_fire0 : w_fire1;
  assign w_own_lock = (r_state == ST_LOCK0) ? io_req0_lock : io_req1_lock;
  assign w_cnt_last = (r_cnt == CNT_W'(LOCK_TIMEOUT - 1));

  // Next state and timeout counter: an owner fire always beats the timeout.
  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = '0;
    w_timeout   = 1'b0;
    if (r_state == ST_IDLE) begin
      if (w_fire0 && io_req0_lock) begin
        w_state_nxt = ST_LOCK0;
      end else if (w_fire1 && io_req1_lock) begin
        w_state_nxt = ST_LOCK1;
      end
    end else if (w_own_fire) begin
      if (!w_own_lock) begin
        w_state_nxt = ST_IDLE;
      end
    end else if (w_cnt_last) begin
      w_state_nxt = ST_IDLE;
      w_timeout   = 1'b1;
    end else begin
      w_cnt_nxt = r_cnt + 1'b1;
    end
  end

  // State, round-robin pointer, read-response flags and sticky timeout flag.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      r_state        <= ST_IDLE;
      r_cnt          <= '0;
      r_last1        <= 1'b1;
      r_resp0_valid  <= 1'b0;
      r_resp1_valid  <= 1'b0;
      r_lock_timeout <= 1'b0;
    end else begin
      r_state        <= w_state_nxt;
      r_cnt          <= w_cnt_nxt;
      if (w_fire0 || w_fire1) begin
        r_last1 <= w_fire1;
      end
      r_resp0_valid  <= w_fire0 & ~io_req0_writeEn;
      r_resp1_valid  <= w_fire1 & ~io_req1_writeEn;
      r_lock_timeout <= r_lock_timeout | w_timeout;
    end
  end

  assign io_req0_ready    = w_fire0;
  assign io_req1_ready    = w_fire1;
  assign io_bram_en       = w_fire0 | w_fire1;
  assign io_bram_writeEn  = (w_fire0 & io_req0_writeEn) | (w_fire1 & io_req1_writeEn);
  assign io_bram_addr     = w_fire1 ? io_req1_addr   : (w_fire0 ? io_req0_addr   : '0);
  assign io_bram_dataIn   = w_fire1 ? io_req1_dataIn : (w_fire0 ? io_req0_dataIn : '0);
  assign io_resp0_valid   = r_resp0_valid;
  assign io_resp1_valid   = r_resp1_valid;
  assign io_resp0_dataOut = r_resp0_valid ? io_bram_dataOut : '0;
  assign io_resp1_dataOut = r_resp1_valid ? io_bram_dataOut : '0;
  assign io_lockTimeout   = r_lock_timeout;

endmodule

// File: tb/tb_bram_port_arbiter.sv
// tb/tb_bram_port_arbiter.sv - scoreboard bench for bram_port_arbiter
module tb_bram_port_arbiter;

  localparam int AW = 10;
  localparam int DW = 36;
  localparam int LT = 16;

  logic          clock = 1'b0;
  logic          reset_n = 1'b1;
  logic          io_req0_valid = 1'b0, io_req0_writeEn = 1'b0, io_req0_lock = 1'b0;
  logic [AW-1:0] io_req0_addr = '0;
  logic [DW-1:0] io_req0_dataIn = '0;
  logic          io_req1_valid = 1'b0, io_req1_writeEn = 1'b0, io_req1_lock = 1'b0;
  logic [AW-1:0] io_req1_addr = '0;
  logic [DW-1:0] io_req1_dataIn = '0;
  logic          io_req0_ready, io_req1_ready;
  logic          io_resp0_valid, io_resp1_valid;
  logic [DW-1:0] io_resp0_dataOut, io_resp1_dataOut;
  logic          io_bram_en, io_bram_writeEn;
  logic [AW-1:0] io_bram_addr;
  logic [DW-1:0] io_bram_dataIn;
  logic [DW-1:0] io_bram_dataOut = '0;
  logic          io_lockTimeout;

  always #5 clock = ~clock;

  bram_port_arbiter #(.ADDR_W(AW), .DATA_W(DW), .LOCK_TIMEOUT(LT)) dut (
    .clock(clock), .reset_n(reset_n),
    .io_req0_valid(io_req0_valid), .io_req0_ready(io_req0_ready),
    .io_req0_writeEn(io_req0_writeEn), .io_req0_lock(io_req0_lock),
    .io_req0_addr(io_req0_addr), .io_req0_dataIn(io_req0_dataIn),
    .io_req1_valid(io_req1_valid), .io_req1_ready(io_req1_ready),
    .io_req1_writeEn(io_req1_writeEn), .io_req1_lock(io_req1_lock),
    .io_req1_addr(io_req1_addr), .io_req1_dataIn(io_req1_dataIn),
    .io_resp0_valid(io_resp0_valid), .io_resp0_dataOut(io_resp0_dataOut),
    .io_resp1_valid(io_resp1_valid), .io_resp1_dataOut(io_resp1_dataOut),
    .io_bram_en(io_bram_en), .io_bram_writeEn(io_bram_writeEn),
    .io_bram_addr(io_bram_addr), .io_bram_dataIn(io_bram_dataIn),
    .io_bram_dataOut(io_bram_dataOut), .io_lockTimeout(io_lockTimeout)
  );

  // Bench-side BRAM: 64 words, one-cycle read latency.
  logic [DW-1:0] bram [0:63];
  bit            bram_init;
  always @(posedge clock) begin
    if (!bram_init) begin
      for (int i = 0; i < 64; i++) bram[i] <= DW'(i * 7 + 1);
      bram_init <= 1'b1;
    end else if (io_bram_en) begin
      if (io_bram_writeEn) bram[io_bram_addr[5:0]] <= io_bram_dataIn;
      else io_bram_dataOut <= bram[io_bram_addr[5:0]];
    end
  end

  typedef struct {
    bit            r0, r1, en, we, to;
    logic [AW-1:0] addr;
    logic [DW-1:0] din;
  } exp_t;
  typedef struct {
    int            due;
    logic [DW-1:0] data;
  } resp_t;

  exp_t  q_exp[$];
  resp_t q_r0[$];
  resp_t q_r1[$];
  int    checks = 0;
  int    errors = 0;
  int    cyc = 0;
  bit    mon_en = 1'b0;

  // Reference model state: owner (-1 = none), last winner, idle cycles of owner, sticky flag.
  int            m_owner = -1;
  int            m_last = 1;
  int            m_idle = 0;
  bit            m_flag = 1'b0;
  logic [DW-1:0] mem_m [0:63];

  always @(posedge clock) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic model_reset();
    m_owner = -1; m_last = 1; m_idle = 0; m_flag = 1'b0;
    q_exp.delete(); q_r0.delete(); q_r1.delete();
  endtask

  // Decide this cycle's winner from the arbitration rules and queue the expected outcome.
  task automatic predict();
    exp_t          e;
    resp_t         r;
    int            g;
    logic          we, lk;
    logic [AW-1:0] a;
    logic [DW-1:0] d;
    g = -1;
    if (m_owner < 0) begin
      if (io_req0_valid && io_req1_valid) g = (m_last == 1) ? 0 : 1;
      else if (io_req0_valid) g = 0;
      else if (io_req1_valid) g = 1;
    end else if (m_owner == 0 && io_req0_valid) g = 0;
    else if (m_owner == 1 && io_req1_valid) g = 1;
    if (g == 0) begin
      we = io_req0_writeEn; lk = io_req0_lock; a = io_req0_addr; d = io_req0_dataIn;
    end else if (g == 1) begin
      we = io_req1_writeEn; lk = io_req1_lock; a = io_req1_addr; d = io_req1_dataIn;
    end else begin
      we = 1'b0; lk = 1'b0; a = '0; d = '0;
    end
    e.r0 = (g == 0); e.r1 = (g == 1); e.en = (g >= 0); e.we = (g >= 0) && we;
    e.to = m_flag; e.addr = a; e.din = d;
    q_exp.push_back(e);
    if (g >= 0) begin
      m_last = g;
      if (we) mem_m[a[5:0]] = d;
      else begin
        r.due = cyc + 1; r.data = mem_m[a[5:0]];
        if (g == 0) q_r0.push_back(r); else q_r1.push_back(r);
      end
    end
    if (m_owner < 0) begin
      if (g >= 0 && lk) begin m_owner = g; m_idle = 0; end
    end else if (g == m_owner) begin
      m_idle = 0;
      if (!lk) m_owner = -1;
    end else begin
      m_idle++;
      if (m_idle == LT) begin m_owner = -1; m_idle = 0; m_flag = 1'b1; end
    end
  endtask

  task automatic step(input logic v0, we0, lk0, input logic [AW-1:0] a0, input logic [DW-1:0] d0,
                      input logic v1, we1, lk1, input logic [AW-1:0] a1, input logic [DW-1:0] d1);
    @(posedge clock);
    #1;
    io_req0_valid = v0; io_req0_writeEn = we0; io_req0_lock = lk0; io_req0_addr = a0; io_req0_dataIn = d0;
    io_req1_valid = v1; io_req1_writeEn = we1; io_req1_lock = lk1; io_req1_addr = a1; io_req1_dataIn = d1;
    #1;
    predict();
  endtask

  task automatic rnd_step(input bit wr_only);
    step(1'($urandom_range(0, 1)), wr_only | 1'($urandom_range(0, 1)), ($urandom_range(0, 3) == 0),
         AW'($urandom_range(0, 63)), DW'({$urandom(), $urandom()}),
         1'($urandom_range(0, 1)), wr_only | 1'($urandom_range(0, 1)), ($urandom_range(0, 3) == 0),
         AW'($urandom_range(0, 63)), DW'({$urandom(), $urandom()}));
  endtask

  task automatic idle_step();
    step(1'b0, 1'b0, 1'b0, '0, '0, 1'b0, 1'b0, 1'b0, '0, '0);
  endtask

  // Monitor: pops one expectation per cycle and checks responses against their due cycle.
  always @(negedge clock) begin
    exp_t  e;
    resp_t r;
    if (mon_en && q_exp.size() > 0) begin
      e = q_exp.pop_front();
      chk("req0_ready", io_req0_ready, e.r0);
      chk("req1_ready", io_req1_ready, e.r1);
      chk("bram_en", io_bram_en, e.en);
      chk("bram_writeEn", io_bram_writeEn, e.we);
      chk("lockTimeout", io_lockTimeout, e.to);
      if (e.en) begin
        chk("bram_addr", io_bram_addr, e.addr);
        chk("bram_dataIn", io_bram_dataIn, e.din);
      end
      if (q_r0.size() > 0 && q_r0[0].due == cyc) begin
        r = q_r0.pop_front();
        chk("resp0_valid", io_resp0_valid, 1);
        chk("resp0_dataOut", io_resp0_dataOut, r.data);
      end else begin
        chk("resp0_valid_idle", io_resp0_valid, 0);
        chk("resp0_dataOut_idle", io_resp0_dataOut, 0);
      end
      if (q_r1.size() > 0 && q_r1[0].due == cyc) begin
        r = q_r1.pop_front();
        chk("resp1_valid", io_resp1_valid, 1);
        chk("resp1_dataOut", io_resp1_dataOut, r.data);
      end else begin
        chk("resp1_valid_idle", io_resp1_valid, 0);
        chk("resp1_dataOut_idle", io_resp1_dataOut, 0);
      end
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish, checks %0d", checks);
    $fatal(1);
  end

  initial begin
    for (int i = 0; i < 64; i++) mem_m[i] = DW'(i * 7 + 1);
    #1 reset_n = 1'b0;
    #1;
    chk("reset_resp0_valid", io_resp0_valid, 0);
    chk("reset_resp1_valid", io_resp1_valid, 0);
    chk("reset_lockTimeout", io_lockTimeout, 0);
    chk("reset_bram_en", io_bram_en, 0);
    repeat (2) @(posedge clock);
    #3 reset_n = 1'b1;
    @(negedge clock);
    #1 mon_en = 1'b1;

    // Both requesters reading every cycle: strict alternation starting at 0.
    for (int i = 0; i < 6; i++)
      step(1'b1, 1'b0, 1'b0, 10'h010, '0, 1'b1, 1'b0, 1'b0, 10'h020, '0);

    // Locked write then unlocking read by req0 while req1 waits.
    step(1'b1, 1'b1, 1'b1, 10'h005, 36'h2A, 1'b1, 1'b0, 1'b0, 10'h020, '0);
    step(1'b1, 1'b0, 1'b0, 10'h005, '0,     1'b1, 1'b0, 1'b0, 10'h020, '0);
    step(1'b0, 1'b0, 1'b0, '0,      '0,     1'b1, 1'b0, 1'b0, 10'h020, '0);

    // Req1 takes the lock and goes quiet: released after LT idle cycles.
    step(1'b0, 1'b0, 1'b0, '0, '0, 1'b1, 1'b0, 1'b1, 10'h007, '0);
    for (int i = 0; i < LT; i++)
      step(1'b1, 1'b0, 1'b0, 10'h003, '0, 1'b0, 1'b0, 1'b0, '0, '0);
    step(1'b1, 1'b0, 1'b0, 10'h003, '0, 1'b0, 1'b0, 1'b0, '0, '0);
    chk("timeout_req0_granted", io_req0_ready, 1);
    chk("timeout_flag_set", io_lockTimeout, 1);
    idle_step();
    chk("timeout_flag_sticky", io_lockTimeout, 1);

    // Asynchronous reset with a read response in flight and valid asserted.
    step(1'b1, 1'b0, 1'b0, 10'h005, '0, 1'b0, 1'b0, 1'b0, '0, '0);
    @(posedge clock);
    #1 mon_en = 1'b0;
    io_req0_valid = 1'b1; io_req0_lock = 1'b1; io_req1_valid = 1'b0;
    #1;
    chk("pre_reset_resp0_valid", io_resp0_valid, 1);
    chk("pre_reset_resp0_data", io_resp0_dataOut, mem_m[5]);
    reset_n = 1'b0;
    #1;
    chk("async_resp0_valid", io_resp0_valid, 0);
    chk("async_resp0_data", io_resp0_dataOut, 0);
    chk("async_bram_en", io_bram_en, 0);
    chk("async_req0_ready", io_req0_ready, 0);
    chk("async_lockTimeout", io_lockTimeout, 0);
    repeat (2) @(posedge clock);
    io_req0_valid = 1'b0; io_req0_lock = 1'b0;
    #3 reset_n = 1'b1;
    model_reset();
    @(negedge clock);
    #1 mon_en = 1'b1;

    // Owner fires exactly on the timeout cycle: lock is kept, no flag.
    step(1'b0, 1'b0, 1'b0, '0, '0, 1'b1, 1'b0, 1'b1, 10'h007, '0);
    for (int i = 0; i < LT - 1; i++)
      step(1'b1, 1'b0, 1'b0, 10'h003, '0, 1'b0, 1'b0, 1'b0, '0, '0);
    step(1'b1, 1'b0, 1'b0, 10'h003, '0, 1'b1, 1'b0, 1'b1, 10'h008, '0);
    step(1'b1, 1'b0, 1'b0, 10'h003, '0, 1'b0, 1'b0, 1'b0, '0, '0);
    chk("edge_still_locked", io_req0_ready, 0);
    chk("edge_no_flag", io_lockTimeout, 0);
    step(1'b1, 1'b0, 1'b0, 10'h003, '0, 1'b1, 1'b0, 1'b0, 10'h009, '0);

    // Writes only: never a response.
    for (int i = 0; i < 40; i++) rnd_step(1'b1);

    // Mixed random traffic.
    for (int i = 0; i < 600; i++) rnd_step(1'b0);

    idle_step();
    idle_step();
    @(negedge clock);
    #1;
    chk("exp_queue_drained", q_exp.size(), 0);
    chk("resp_queues_drained", q_r0.size() + q_r1.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
